mem_arbiter: RTL and testbench

Parametrised N-port memory arbiter merging the core's separate instruction and data memory requesters (fetch buffer/ITIM path, store buffer/DTIM path, and future masters such as a debug or DMA port) onto one shared memory port. Each requester uses the core's mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb → mem_rdata/mem_ready handshake. The block captures single-cycle requests per port, arbitrates with a fixed-priority or round-robin policy, and keeps exactly one transaction in flight on the memory side. It sits between the core's ITIM/DTIM outputs and the external memory interface, replacing the two independent imemory/dmemory buses.

---
 rtl/mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Merges NUM_PORTS independent memory requesters (port 0 is normally the
// instruction fetch path) onto one shared memory port with a single
// transaction in flight. Each port owns a one-entry pending slot. Arbitration
// is either fixed priority (lowest index wins) or round-robin.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   mst_valid  one-cycle request pulse per port
//   mst_instr  instruction-fetch flag per port
//   mst_addr   packed request addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   mst_wdata  packed write data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   mst_wstrb  packed byte strobes (0 = read)
//   mst_rdata  read data broadcast to all ports (valid while mem_ready)
//   mst_ready  one-cycle completion pulse per port
//   mem_valid  shared request, held until mem_ready
//   mem_instr / mem_addr / mem_wdata / mem_wstrb  forwarded request fields
//   mem_port   index of the granted port
//   mem_rdata  memory read data
//   mem_ready  memory completion pulse
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RR_MODE    = 0,
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int SW = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           mst_valid,
  input  logic [NUM_PORTS-1:0]           mst_instr,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] mst_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] mst_wdata,
  input  logic [NUM_PORTS*SW-1:0]        mst_wstrb,
  output logic [DATA_WIDTH-1:0]          mst_rdata,
  output logic [NUM_PORTS-1:0]           mst_ready,
  output logic                           mem_valid,
  output logic                           mem_instr,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_wdata,
  output logic [SW-1:0]                  mem_wstrb,
  output logic [PW-1:0]                  mem_port,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  input  logic                           mem_ready
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                state_q;
  logic [NUM_PORTS-1:0]  slotValid_q;
  logic [NUM_PORTS-1:0]  slotInstr_q;
  logic [ADDR_WIDTH-1:0] slotAddr_q  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] slotWdata_q [NUM_PORTS];
  logic [SW-1:0]         slotWstrb_q [NUM_PORTS];
  logic [PW-1:0]         lastGrant_q;
  logic                  memValid_q;
  logic                  memInstr_q;
  logic [ADDR_WIDTH-1:0] memAddr_q;
  logic [DATA_WIDTH-1:0] memWdata_q;
  logic [SW-1:0]         memWstrb_q;
  logic [PW-1:0]         memPort_q;

  logic [ADDR_WIDTH-1:0] inAddr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] inWdata [NUM_PORTS];
  logic [SW-1:0]         inWstrb [NUM_PORTS];

  logic [NUM_PORTS-1:0]  incoming;
  logic [NUM_PORTS-1:0]  cand;
  logic [NUM_PORTS-1:0]  candRot;
  logic                  anyCand;
  logic                  grant;
  logic                  found;
  logic [PW-1:0]         winner;
  logic                  winInstr_d;
  logic [ADDR_WIDTH-1:0] winAddr_d;
  logic [DATA_WIDTH-1:0] winWdata_d;
  logic [SW-1:0]         winWstrb_d;

  // Unpack the flat per-port request buses into arrays.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      inAddr[i]  = mst_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      inWdata[i] = mst_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      inWstrb[i] = mst_wstrb[i*SW +: SW];
    end
  end

  // Candidate set and winner. A pulse is dropped if its slot is full or the
  // port is still in flight; in the completion cycle the port is free again.
  always_comb begin
    incoming = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      incoming[i] = mst_valid[i] && !slotValid_q[i] &&
                    !(state_q == BUSY && !mem_ready && memPort_q == PW'(i));
    end
    cand    = slotValid_q | incoming;
    anyCand = |cand;
    grant   = anyCand && (state_q == IDLE || mem_ready);
    winner  = '0;
    found   = 1'b0;
    candRot = '0;
    if (RR_MODE == 0) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!found && cand[i]) begin
          winner = PW'(i);
          found  = 1'b1;
        end
      end
    end else begin
      // Search starts one past the last grant and wraps.
      for (int k = 1; k <= NUM_PORTS; k++) begin
        candRot = cand >> ((int'(lastGrant_q) + k) % NUM_PORTS);
        if (!found && candRot[0]) begin
          winner = PW'((int'(lastGrant_q) + k) % NUM_PORTS);
          found  = 1'b1;
        end
      end
    end
    // A full slot holds the winner's request; otherwise it arrives this cycle.
    if (slotValid_q[winner]) begin
      winInstr_d = slotInstr_q[winner];
      winAddr_d  = slotAddr_q[winner];
      winWdata_d = slotWdata_q[winner];
      winWstrb_d = slotWstrb_q[winner];
    end else begin
      winInstr_d = mst_instr[winner];
      winAddr_d  = inAddr[winner];
      winWdata_d = inWdata[winner];
      winWstrb_d = inWstrb[winner];
    end
  end

  // Slots, FSM and registered memory-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      slotValid_q <= '0;
      slotInstr_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        slotAddr_q[i]  <= '0;
        slotWdata_q[i] <= '0;
        slotWstrb_q[i] <= '0;
      end
      lastGrant_q <= PW'(NUM_PORTS - 1);
      memValid_q  <= 1'b0;
      memInstr_q  <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      memWstrb_q  <= '0;
      memPort_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant && winner == PW'(i)) begin
          slotValid_q[i] <= 1'b0;
        end else if (incoming[i]) begin
          slotValid_q[i] <= 1'b1;
          slotInstr_q[i] <= mst_instr[i];
          slotAddr_q[i]  <= inAddr[i];
          slotWdata_q[i] <= inWdata[i];
          slotWstrb_q[i] <= inWstrb[i];
        end
      end
      if (grant) begin
        state_q     <= BUSY;
        memValid_q  <= 1'b1;
        memInstr_q  <= winInstr_d;
        memAddr_q   <= winAddr_d;
        memWdata_q  <= winWdata_d;
        memWstrb_q  <= winWstrb_d;
        memPort_q   <= winner;
        lastGrant_q <= winner;
      end else if (state_q == BUSY && mem_ready) begin
        state_q    <= IDLE;
        memValid_q <= 1'b0;
      end
    end
  end

  assign mem_valid = memValid_q;
  assign mem_instr = memInstr_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign mem_wstrb = memWstrb_q;
  assign mem_port  = memPort_q;

  // Completion is combinational from mem_ready; ignored while idle.
  assign mst_ready = (state_q == BUSY && mem_ready) ? (NUM_PORTS'(1) << memPort_q) : '0;
  assign mst_rdata = mem_ready ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. Three instances share clock and reset:
//   dutA  2 ports, fixed priority
//   dutB  4 ports, round-robin
//   dutC  3 ports, round-robin
// Inputs change 2 time units after each rising edge; outputs are sampled one
// unit later, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Instance A: 2 ports, fixed priority
  logic [1:0]  aValid, aInstr, aReady;
  logic [63:0] aAddr, aWdata;
  logic [7:0]  aWstrb;
  logic [31:0] aRdata, aMemAddr, aMemWdata, aMemRdata;
  logic        aMemValid, aMemInstr, aMemReady;
  logic [3:0]  aMemWstrb;
  logic [0:0]  aMemPort;

  // Instance B: 4 ports, round-robin
  logic [3:0]   bValid, bInstr, bReady;
  logic [127:0] bAddr, bWdata;
  logic [15:0]  bWstrb;
  logic [31:0]  bRdata, bMemAddr, bMemWdata, bMemRdata;
  logic         bMemValid, bMemInstr, bMemReady;
  logic [3:0]   bMemWstrb;
  logic [1:0]   bMemPort;

  // Instance C: 3 ports, round-robin
  logic [2:0]  cValid, cInstr, cReady;
  logic [95:0] cAddr, cWdata;
  logic [11:0] cWstrb;
  logic [31:0] cRdata, cMemAddr, cMemWdata, cMemRdata;
  logic        cMemValid, cMemInstr, cMemReady;
  logic [3:0]  cMemWstrb;
  logic [1:0]  cMemPort;

  mem_arbiter #(.NUM_PORTS(2), .RR_MODE(0)) dutA (
    .clk(clk), .rst(rst),
    .mst_valid(aValid), .mst_instr(aInstr), .mst_addr(aAddr),
    .mst_wdata(aWdata), .mst_wstrb(aWstrb), .mst_rdata(aRdata),
    .mst_ready(aReady), .mem_valid(aMemValid), .mem_instr(aMemInstr),
    .mem_addr(aMemAddr), .mem_wdata(aMemWdata), .mem_wstrb(aMemWstrb),
    .mem_port(aMemPort), .mem_rdata(aMemRdata), .mem_ready(aMemReady)
  );

  mem_arbiter #(.NUM_PORTS(4), .RR_MODE(1)) dutB (
    .clk(clk), .rst(rst),
    .mst_valid(bValid), .mst_instr(bInstr), .mst_addr(bAddr),
    .mst_wdata(bWdata), .mst_wstrb(bWstrb), .mst_rdata(bRdata),
    .mst_ready(bReady), .mem_valid(bMemValid), .mem_instr(bMemInstr),
    .mem_addr(bMemAddr), .mem_wdata(bMemWdata), .mem_wstrb(bMemWstrb),
    .mem_port(bMemPort), .mem_rdata(bMemRdata), .mem_ready(bMemReady)
  );

  mem_arbiter #(.NUM_PORTS(3), .RR_MODE(1)) dutC (
    .clk(clk), .rst(rst),
    .mst_valid(cValid), .mst_instr(cInstr), .mst_addr(cAddr),
    .mst_wdata(cWdata), .mst_wstrb(cWstrb), .mst_rdata(cRdata),
    .mst_ready(cReady), .mem_valid(cMemValid), .mem_instr(cMemInstr),
    .mem_addr(cMemAddr), .mem_wdata(cMemWdata), .mem_wstrb(cMemWstrb),
    .mem_port(cMemPort), .mem_rdata(cMemRdata), .mem_ready(cMemReady)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts every comparison and reports any disagreement.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives every input of instance A for the current cycle.
  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] instr,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [7:0] wstrb, input logic memReady,
                               input logic [31:0] memRdata);
    aValid    = valid;
    aInstr    = instr;
    aAddr     = addr;
    aWdata    = wdata;
    aWstrb    = wstrb;
    aMemReady = memReady;
    aMemRdata = memRdata;
  endtask

  // Moves to the drive point of the next cycle.
  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b0, 32'h0);
    bValid = '0; bInstr = '0; bWdata = '0; bWstrb = '0; bMemReady = 1'b0; bMemRdata = '0;
    bAddr  = {32'h40, 32'h30, 32'h20, 32'h10};
    cValid = '0; cInstr = '0; cWdata = '0; cWstrb = '0; cMemReady = 1'b0; cMemRdata = '0;
    cAddr  = {32'hC00, 32'hB00, 32'hA00};
    #1 rst = 1'b0;
    #2;
    checkOutput("rst_memValid", 64'(aMemValid), 64'h0);
    checkOutput("rst_memAddr", 64'(aMemAddr), 64'h0);
    checkOutput("rst_memPort", 64'(aMemPort), 64'h0);
    checkOutput("rst_mstReady", 64'(aReady), 64'h0);
    checkOutput("rst_mstRdata", 64'(aRdata), 64'h0);
    checkOutput("rst_bMemValid", 64'(bMemValid), 64'h0);
    nextCycle();
    nextCycle();
    rst = 1'b1;

    // Single read from port 1
    nextCycle();
    applyStimulus(2'b10, 2'b00, {32'h1000, 32'h0}, 64'h0, 8'h0, 1'b0, 32'h0);
    #1 checkOutput("read_noCombPath", 64'(aMemValid), 64'h0);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b0, 32'h0);
    #1;
    checkOutput("read_memValid", 64'(aMemValid), 64'h1);
    checkOutput("read_memAddr", 64'(aMemAddr), 64'h1000);
    checkOutput("read_memPort", 64'(aMemPort), 64'h1);
    checkOutput("read_memWstrb", 64'(aMemWstrb), 64'h0);
    nextCycle();
    #1 checkOutput("read_hold", 64'(aMemValid), 64'h1);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b1, 32'hDEADBEEF);
    #1;
    checkOutput("read_mstReady", 64'(aReady), 64'h2);
    checkOutput("read_mstRdata", 64'(aRdata), 64'hDEADBEEF);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b0, 32'h0);
    #1;
    checkOutput("read_idle", 64'(aMemValid), 64'h0);
    checkOutput("read_readyLow", 64'(aReady), 64'h0);

    // Fixed-priority conflict: port 0 instr fetch vs port 1 write
    nextCycle();
    applyStimulus(2'b11, 2'b01, {32'h200, 32'h100}, {32'h55, 32'h0}, 8'hF0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b0, 32'h0);
    #1;
    checkOutput("fp_firstPort", 64'(aMemPort), 64'h0);
    checkOutput("fp_firstAddr", 64'(aMemAddr), 64'h100);
    checkOutput("fp_firstInstr", 64'(aMemInstr), 64'h1);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b1, 32'h11111111);
    #1;
    checkOutput("fp_ready0", 64'(aReady), 64'h1);
    checkOutput("fp_rdata0", 64'(aRdata), 64'h11111111);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b0, 32'h0);
    #1;
    checkOutput("fp_noGap", 64'(aMemValid), 64'h1);
    checkOutput("fp_secondPort", 64'(aMemPort), 64'h1);
    checkOutput("fp_secondAddr", 64'(aMemAddr), 64'h200);
    checkOutput("fp_secondWdata", 64'(aMemWdata), 64'h55);
    checkOutput("fp_secondWstrb", 64'(aMemWstrb), 64'hF);
    checkOutput("fp_secondInstr", 64'(aMemInstr), 64'h0);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b1, 32'h0);
    #1 checkOutput("fp_ready1", 64'(aReady), 64'h2);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b0, 32'h0);
    #1 checkOutput("fp_idle", 64'(aMemValid), 64'h0);

    // Illegal re-issue while in flight is dropped
    nextCycle();
    applyStimulus(2'b01, 2'b00, {32'h0, 32'h300}, 64'h0, 8'h0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(2'b01, 2'b00, {32'h0, 32'h400}, 64'h0, 8'h0, 1'b0, 32'h0);
    #1 checkOutput("dup_addr", 64'(aMemAddr), 64'h300);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b1, 32'h0);
    #1 checkOutput("dup_ready", 64'(aReady), 64'h1);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b0, 32'h0);
    #1 checkOutput("dup_oneTxn", 64'(aMemValid), 64'h0);
    nextCycle();
    #1 checkOutput("dup_stillIdle", 64'(aMemValid), 64'h0);

    // Re-request from the completing port in its completion cycle
    nextCycle();
    applyStimulus(2'b01, 2'b00, {32'h0, 32'h500}, 64'h0, 8'h0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b0, 32'h0);
    #1 checkOutput("rereq_firstAddr", 64'(aMemAddr), 64'h500);
    nextCycle();
    applyStimulus(2'b01, 2'b00, {32'h0, 32'h600}, 64'h0, 8'h0, 1'b1, 32'h0);
    #1 checkOutput("rereq_ready", 64'(aReady), 64'h1);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b0, 32'h0);
    #1;
    checkOutput("rereq_valid", 64'(aMemValid), 64'h1);
    checkOutput("rereq_addr", 64'(aMemAddr), 64'h600);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b1, 32'h0);
    #1 checkOutput("rereq_ready2", 64'(aReady), 64'h1);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b1, 32'h0);
    #1 checkOutput("idleReady_ignored", 64'(aReady), 64'h0);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b0, 32'h0);
    #1 checkOutput("idleReady_noTxn", 64'(aMemValid), 64'h0);

    // Round-robin fairness on 4 ports, each port re-requests on completion
    nextCycle();
    bValid = 4'b1111;
    for (int g = 0; g < 8; g++) begin
      nextCycle();
      bValid    = 4'b0000;
      bMemReady = 1'b0;
      #1;
      checkOutput($sformatf("rr_valid%0d", g), 64'(bMemValid), 64'h1);
      checkOutput($sformatf("rr_port%0d", g), 64'(bMemPort), 64'(g % 4));
      checkOutput($sformatf("rr_addr%0d", g), 64'(bMemAddr), 64'(((g % 4) + 1) * 16));
      nextCycle();
      bMemReady = 1'b1;
      bValid    = 4'b0001 << (g % 4);
      #1 checkOutput($sformatf("rr_ready%0d", g), 64'(bReady), 64'(4'b0001 << (g % 4)));
    end
    nextCycle();
    bValid    = 4'b0000;
    bMemReady = 1'b0;

    // Wrap-around on 3 ports: last grant 2, then ports 0 and 2 request
    nextCycle();
    cValid = 3'b100;
    nextCycle();
    cValid = 3'b000;
    #1 checkOutput("wrap_firstPort", 64'(cMemPort), 64'h2);
    nextCycle();
    cMemReady = 1'b1;
    cValid    = 3'b101;
    #1 checkOutput("wrap_ready2", 64'(cReady), 64'h4);
    nextCycle();
    cMemReady = 1'b0;
    cValid    = 3'b000;
    #1;
    checkOutput("wrap_winner", 64'(cMemPort), 64'h0);
    checkOutput("wrap_addr", 64'(cMemAddr), 64'hA00);
    nextCycle();
    cMemReady = 1'b1;
    #1 checkOutput("wrap_ready0", 64'(cReady), 64'h1);
    nextCycle();
    cMemReady = 1'b0;
    #1 checkOutput("wrap_then2", 64'(cMemPort), 64'h2);
    nextCycle();
    cMemReady = 1'b1;
    nextCycle();
    cMemReady = 1'b0;
    #1 checkOutput("wrap_idle", 64'(cMemValid), 64'h0);

    // Asynchronous reset while a transaction is in flight
    nextCycle();
    applyStimulus(2'b10, 2'b00, {32'h700, 32'h0}, 64'h0, 8'h0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b0, 32'h0);
    #1 checkOutput("midrst_busy", 64'(aMemValid), 64'h1);
    #1 rst = 1'b0;
    #1;
    checkOutput("midrst_validDrop", 64'(aMemValid), 64'h0);
    checkOutput("midrst_readyLow", 64'(aReady), 64'h0);
    checkOutput("midrst_addrClear", 64'(aMemAddr), 64'h0);
    nextCycle();
    nextCycle();
    rst = 1'b1;
    nextCycle();
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b1, 32'h12345678);
    #1;
    checkOutput("midrst_lateReady", 64'(aReady), 64'h0);
    checkOutput("midrst_stayIdle", 64'(aMemValid), 64'h0);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b0, 32'h0);
    #1 checkOutput("midrst_noTxn", 64'(aMemValid), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
